// File: rtl/motor_pwm_pkg.sv
// Shared types and elaboration-time helpers for the motor PWM bank.
// Direction encoding plus PWM period and duty-threshold derivation.
package motor_pwm_pkg;

  typedef enum logic [1:0] {
    DIR_COAST = 2'd0,
    DIR_FWD   = 2'd1,
    DIR_REV   = 2'd2
  } dir_e;

  // Counter period in system clocks.
  function automatic int calc_period(input int clk_freq, input int pwm_freq);
    return clk_freq / pwm_freq;
  endfunction

  // Duty threshold in counts for a percentage of the period (truncating).
  function automatic int calc_duty(input int pct, input int period);
    return (pct * period) / 100;
  endfunction

  // Bits needed to hold the values 0..max_val.
  function automatic int calc_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/motor_pwm_chan.sv
// One motor channel: sample register, pending threshold/direction computed
// one cycle after capture, active copy loaded at the counter wrap, and the
// registered H-bridge output mux with brake override.
// Optional build macro: MOTOR_PWM_DEADTIME_EN adds a dead-time down-counter
// that blanks both gates after a FWD<->REV reversal.
module motor_pwm_chan
  import motor_pwm_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int CNT_W        = 9,
  parameter int RPM_MAX      = 1500,
  parameter int DMIN         = 54,
  parameter int DMAX         = 216,
  parameter int DEADTIME_CYC = 27
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cap_en,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  wrap,
  input  logic [CNT_W-1:0]      cnt_nxt,
  input  logic                  stop,
  output logic                  in_1,
  output logic                  in_2
);

  localparam int MAG_W  = calc_width(RPM_MAX);
  localparam int SPAN   = DMAX - DMIN;
  localparam int PROD_W = MAG_W + calc_width(SPAN);
  localparam logic [DATA_WIDTH:0] RPM_MAX_X = (DATA_WIDTH + 1)'(RPM_MAX);

  logic [DATA_WIDTH-1:0] sample_q;
  logic [DATA_WIDTH-1:0] mag_raw;
  logic [MAG_W-1:0]      mag_sat;
  logic [PROD_W-1:0]     prod;
  logic [PROD_W-1:0]     quot;
  logic [CNT_W-1:0]      thr_calc;
  dir_e                  dir_calc;

  logic [CNT_W-1:0]      pend_thr_q;
  dir_e                  pend_dir_q;
  logic [CNT_W-1:0]      act_thr_q;
  dir_e                  act_dir_q;
  logic [CNT_W-1:0]      act_thr_nxt;
  dir_e                  act_dir_nxt;
  logic                  pwm_nxt;
  logic                  blank_nxt;

  // Sample register: latest accepted PID value for this channel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_q <= '0;
    end else if (cap_en) begin
      sample_q <= cap_data;
    end
  end

  // Magnitude (most-negative value handled as unsigned), saturation, and
  // linear mapping into [DMIN, DMAX]; zero input means coast with thr 0.
  always_comb begin
    mag_raw  = sample_q[DATA_WIDTH-1] ? (-sample_q) : sample_q;
    mag_sat  = MAG_W'(mag_raw);
    if ({1'b0, mag_raw} >= RPM_MAX_X) begin
      mag_sat = MAG_W'(RPM_MAX);
    end
    prod     = PROD_W'(mag_sat) * PROD_W'(SPAN);
    quot     = prod / PROD_W'(RPM_MAX);
    thr_calc = CNT_W'(DMIN) + CNT_W'(quot);
    dir_calc = DIR_FWD;
    if (sample_q == '0) begin
      thr_calc = '0;
      dir_calc = DIR_COAST;
    end else if (sample_q[DATA_WIDTH-1]) begin
      dir_calc = DIR_REV;
    end
  end

  // Pending registers follow the sample with one cycle of latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_thr_q <= '0;
      pend_dir_q <= DIR_COAST;
    end else begin
      pend_thr_q <= thr_calc;
      pend_dir_q <= dir_calc;
    end
  end

  // Values the active registers will hold after this edge.
  always_comb begin
    act_thr_nxt = act_thr_q;
    act_dir_nxt = act_dir_q;
    if (wrap) begin
      act_thr_nxt = pend_thr_q;
      act_dir_nxt = pend_dir_q;
    end
    pwm_nxt = (cnt_nxt < act_thr_nxt);
  end

  // Active registers change only at the wrap so every period is whole.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_thr_q <= '0;
      act_dir_q <= DIR_COAST;
    end else begin
      act_thr_q <= act_thr_nxt;
      act_dir_q <= act_dir_nxt;
    end
  end

`ifdef MOTOR_PWM_DEADTIME_EN
  localparam int DT_W = calc_width(DEADTIME_CYC);

  logic [DT_W-1:0] dt_cnt_q;
  logic [DT_W-1:0] dt_cnt_nxt;
  logic            reversal;

  // Reload the dead-time counter on a FWD<->REV swap at the wrap, then
  // count down to zero; both gates are blanked while it is non-zero.
  always_comb begin
    reversal = ((act_dir_q == DIR_FWD) && (pend_dir_q == DIR_REV)) ||
               ((act_dir_q == DIR_REV) && (pend_dir_q == DIR_FWD));
    dt_cnt_nxt = dt_cnt_q;
    if (wrap) begin
      dt_cnt_nxt = reversal ? DT_W'(DEADTIME_CYC) : '0;
    end else if (dt_cnt_q != '0) begin
      dt_cnt_nxt = dt_cnt_q - DT_W'(1);
    end
    blank_nxt = (dt_cnt_nxt != '0);
  end

  // Dead-time down-counter state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dt_cnt_q <= '0;
    end else begin
      dt_cnt_q <= dt_cnt_nxt;
    end
  end
`else
  assign blank_nxt = 1'b0;
`endif

  // Registered gate drives: brake wins, then dead-time blanking, then PWM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_1 <= 1'b0;
      in_2 <= 1'b0;
    end else if (stop) begin
      in_1 <= 1'b1;
      in_2 <= 1'b1;
    end else if (blank_nxt) begin
      in_1 <= 1'b0;
      in_2 <= 1'b0;
    end else begin
      case (act_dir_nxt)
        DIR_FWD: begin
          in_1 <= pwm_nxt;
          in_2 <= 1'b0;
        end
        DIR_REV: begin
          in_1 <= 1'b0;
          in_2 <= pwm_nxt;
        end
        default: begin
          in_1 <= 1'b0;
          in_2 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/motor_pwm_bank.sv
// Bank of H-bridge PWM channels driven by PID samples.
// Shared period counter and sample-capture decode live here; each channel
// is a motor_pwm_chan instance.
// Optional build macro: MOTOR_PWM_DEADTIME_EN (reversal dead-time).
module motor_pwm_bank
  import motor_pwm_pkg::*;
#(
  parameter int NUM_CHN      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int CHN_WIDTH    = 3,
  parameter int RPM_MAX      = 1500,
  parameter int CLK_FREQ     = 27_000_000,
  parameter int PWM_FREQ     = 100_000,
  parameter int DUTY_MIN_PCT = 20,
  parameter int DUTY_MAX_PCT = 80,
  parameter int DEADTIME_CYC = 27
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  u_valid_i,
  input  logic [CHN_WIDTH-1:0]  u_chn_i,
  input  logic [DATA_WIDTH-1:0] u_data_i,
  input  logic [NUM_CHN-1:0]    motor_stop_i,
  output logic [NUM_CHN-1:0]    in_1_o,
  output logic [NUM_CHN-1:0]    in_2_o,
  output logic                  period_start_o,
  output logic                  chn_err_o
);

  localparam int PERIOD = calc_period(CLK_FREQ, PWM_FREQ);
  localparam int DMIN   = calc_duty(DUTY_MIN_PCT, PERIOD);
  localparam int DMAX   = calc_duty(DUTY_MAX_PCT, PERIOD);
  localparam int CNT_W  = calc_width(PERIOD);

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CHN_WIDTH:0] NUM_CHN_X = (CHN_WIDTH + 1)'(NUM_CHN);

  logic               run_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               wrap;
  logic               chn_bad;
  logic [NUM_CHN-1:0] cap_en;

  // The first edge after reset is treated as a wrap so the counter starts
  // at 0 with period_start aligned to it.
  always_comb begin
    wrap    = !run_q || (cnt_q == CNT_LAST);
    cnt_nxt = wrap ? '0 : (cnt_q + CNT_W'(1));
  end

  // Shared PWM period counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= 1'b1;
      cnt_q <= cnt_nxt;
    end
  end

  // Channel-index decode: one capture strobe per channel, error on overrange.
  always_comb begin
    cap_en  = '0;
    chn_bad = u_valid_i && ({1'b0, u_chn_i} >= NUM_CHN_X);
    for (int k = 0; k < NUM_CHN; k++) begin
      cap_en[k] = u_valid_i && ({1'b0, u_chn_i} == (CHN_WIDTH + 1)'(k));
    end
  end

  // Registered status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      period_start_o <= 1'b0;
      chn_err_o      <= 1'b0;
    end else begin
      period_start_o <= wrap;
      chn_err_o      <= chn_bad;
    end
  end

  for (genvar g = 0; g < NUM_CHN; g++) begin : g_chan
    motor_pwm_chan #(
      .DATA_WIDTH   (DATA_WIDTH),
      .CNT_W        (CNT_W),
      .RPM_MAX      (RPM_MAX),
      .DMIN         (DMIN),
      .DMAX         (DMAX),
      .DEADTIME_CYC (DEADTIME_CYC)
    ) u_chan (
      .clk      (clk),
      .rstn     (rstn),
      .cap_en   (cap_en[g]),
      .cap_data (u_data_i),
      .wrap     (wrap),
      .cnt_nxt  (cnt_nxt),
      .stop     (motor_stop_i[g]),
      .in_1     (in_1_o[g]),
      .in_2     (in_2_o[g])
    );
  end

endmodule

// File: tb/tb_motor_pwm_bank.sv
// Self-checking bench for motor_pwm_bank (default parameters).
// Build with MOTOR_PWM_DEADTIME_EN defined to exercise the dead-time variant.
module tb_motor_pwm_bank;

  localparam int NUM_CHN    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int CHN_WIDTH  = 3;
  localparam int RPM_MAX    = 1500;
  localparam int PERIOD     = 270;
  localparam int DMIN       = 54;
  localparam int DMAX       = 216;
  localparam int DEADTIME   = 27;
`ifdef MOTOR_PWM_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  logic                  clk;
  logic                  rstn;
  logic                  u_valid_i;
  logic [CHN_WIDTH-1:0]  u_chn_i;
  logic [DATA_WIDTH-1:0] u_data_i;
  logic [NUM_CHN-1:0]    motor_stop_i;
  logic [NUM_CHN-1:0]    in_1_o;
  logic [NUM_CHN-1:0]    in_2_o;
  logic                  period_start_o;
  logic                  chn_err_o;

  motor_pwm_bank #(
    .NUM_CHN      (NUM_CHN),
    .DATA_WIDTH   (DATA_WIDTH),
    .CHN_WIDTH    (CHN_WIDTH),
    .RPM_MAX      (RPM_MAX),
    .CLK_FREQ     (27_000_000),
    .PWM_FREQ     (100_000),
    .DUTY_MIN_PCT (20),
    .DUTY_MAX_PCT (80),
    .DEADTIME_CYC (DEADTIME)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .u_valid_i      (u_valid_i),
    .u_chn_i        (u_chn_i),
    .u_data_i       (u_data_i),
    .motor_stop_i   (motor_stop_i),
    .in_1_o         (in_1_o),
    .in_2_o         (in_2_o),
    .period_start_o (period_start_o),
    .chn_err_o      (chn_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: counter position (-1 = not yet started), last
  // captures with the edge they happened on, and the per-period active value.
  int m_cnt;
  int m_edge;
  int m_cap      [NUM_CHN];
  int m_cap_old  [NUM_CHN];
  int m_cap_edge [NUM_CHN];
  int m_act      [NUM_CHN];
  bit m_dt       [NUM_CHN];
  logic [NUM_CHN-1:0] e_in1, e_in2;
  logic e_ps, e_err;
  logic [NUM_CHN-1:0] stop_r;

  function automatic int exp_dir(input int u);
    if (u == 0) return 0;
    return (u > 0) ? 1 : 2;
  endfunction

  function automatic int exp_thr(input int u);
    int mag;
    if (u == 0) return 0;
    mag = (u < 0) ? -u : u;
    if (mag > RPM_MAX) mag = RPM_MAX;
    return DMIN + (mag * (DMAX - DMIN)) / RPM_MAX;
  endfunction

  task automatic model_reset();
    m_cnt  = -1;
    m_edge = 0;
    for (int c = 0; c < NUM_CHN; c++) begin
      m_cap[c]      = 0;
      m_cap_old[c]  = 0;
      m_cap_edge[c] = -100;
      m_act[c]      = 0;
      m_dt[c]       = 1'b0;
    end
    e_in1 = '0;
    e_in2 = '0;
    e_ps  = 1'b0;
    e_err = 1'b0;
  endtask

  // Advance the model over one clock edge given the inputs seen at that edge.
  // A capture reaches the next period only if it happened two or more edges
  // before the wrap (capture, then one cycle to compute the threshold).
  task automatic model_edge(input logic v, input int ch, input int data,
                            input logic [NUM_CHN-1:0] stp);
    int nu;
    bit pwm;
    m_edge++;
    e_err = v && (ch >= NUM_CHN);
    if (v && (ch < NUM_CHN)) begin
      m_cap_old[ch]  = m_cap[ch];
      m_cap[ch]      = data;
      m_cap_edge[ch] = m_edge;
    end
    m_cnt = (m_cnt < 0) ? 0 : (m_cnt + 1) % PERIOD;
    e_ps  = (m_cnt == 0);
    if (m_cnt == 0) begin
      for (int c = 0; c < NUM_CHN; c++) begin
        nu = (m_cap_edge[c] <= m_edge - 2) ? m_cap[c] : m_cap_old[c];
        m_dt[c] = DT_EN && (((exp_dir(m_act[c]) == 1) && (exp_dir(nu) == 2)) ||
                            ((exp_dir(m_act[c]) == 2) && (exp_dir(nu) == 1)));
        m_act[c] = nu;
      end
    end
    for (int c = 0; c < NUM_CHN; c++) begin
      pwm = (m_cnt < exp_thr(m_act[c]));
      e_in1[c] = 1'b0;
      e_in2[c] = 1'b0;
      if (stp[c]) begin
        e_in1[c] = 1'b1;
        e_in2[c] = 1'b1;
      end else if (!(m_dt[c] && (m_cnt < DEADTIME))) begin
        if (exp_dir(m_act[c]) == 1) e_in1[c] = pwm;
        if (exp_dir(m_act[c]) == 2) e_in2[c] = pwm;
      end
    end
  endtask

  task automatic compare();
    checks++;
    if ((in_1_o !== e_in1) || (in_2_o !== e_in2)) begin
      failures++;
      $display("FAIL gates cnt=%0d actual in_1=%b in_2=%b expected in_1=%b in_2=%b",
               m_cnt, in_1_o, in_2_o, e_in1, e_in2);
    end
    checks++;
    if (period_start_o !== e_ps) begin
      failures++;
      $display("FAIL period_start cnt=%0d actual=%b expected=%b", m_cnt, period_start_o, e_ps);
    end
    checks++;
    if (chn_err_o !== e_err) begin
      failures++;
      $display("FAIL chn_err cnt=%0d actual=%b expected=%b", m_cnt, chn_err_o, e_err);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at
  // the next falling edge.
  task automatic cycle(input logic v, input int ch, input int data);
    u_valid_i    = v;
    u_chn_i      = ch[CHN_WIDTH-1:0];
    u_data_i     = data[DATA_WIDTH-1:0];
    motor_stop_i = stop_r;
    @(posedge clk);
    model_edge(v, ch, data, stop_r);
    @(negedge clk);
    compare();
    u_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0);
  endtask

  // Run until the model sits in a counter==0 cycle (at most one period).
  task automatic wait_wrap();
    do cycle(1'b0, 0, 0); while (m_cnt != 0);
  endtask

  // Count high cycles over one full period starting at the current cycle.
  task automatic measure(input int ch, output int hi1, output int hi2, output int first2);
    hi1 = 0;
    hi2 = 0;
    first2 = -1;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) cycle(1'b0, 0, 0);
      hi1 += int'(in_1_o[ch]);
      hi2 += int'(in_2_o[ch]);
      if (in_2_o[ch] && (first2 < 0)) first2 = i;
    end
  endtask

  typedef struct {
    int ch;
    int u;
    int exp_hi1;
    int exp_hi2;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi1, hi2, first2;
    logic v;
    int ch, d;
    logic [31:0] r;

    tbl[0] = '{0,    750, 135,   0};
    tbl[1] = '{1,  -2000,   0, 216};
    tbl[2] = '{1, -32768,   0, 216};
    tbl[3] = '{2,      0,   0,   0};
    tbl[4] = '{0,      1,  54,   0};
    tbl[5] = '{3,     -1,   0,  54};
    tbl[6] = '{2,  32767, 216,   0};
    tbl[7] = '{0,    100,  64,   0};
    tbl[8] = '{3,  -1499,   0, 215};
    tbl[9] = '{2,   1500, 216,   0};

    rstn = 1'b0;
    u_valid_i = 1'b0;
    u_chn_i = '0;
    u_data_i = '0;
    stop_r = '0;
    motor_stop_i = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare();
    end
    rstn = 1'b1;
    cycle(1'b0, 0, 0);
    chk("first_period_start", int'(period_start_o), 1);

    // Directed duty / direction table.
    for (int i = 0; i < 10; i++) begin
      idle(5);
      cycle(1'b1, tbl[i].ch, tbl[i].u);
      wait_wrap();
      measure(tbl[i].ch, hi1, hi2, first2);
      chk($sformatf("tbl%0d_in1_high", i), hi1, tbl[i].exp_hi1);
      chk($sformatf("tbl%0d_in2_high", i), hi2, tbl[i].exp_hi2);
    end

    // Out-of-range channel index: error pulse, no channel affected.
    idle(5);
    cycle(1'b1, 5, 1234);
    chk("chn_err_pulse", int'(chn_err_o), 1);
    cycle(1'b0, 0, 0);
    chk("chn_err_clear", int'(chn_err_o), 0);
    wait_wrap();
    measure(0, hi1, hi2, first2);
    chk("bad_chn_ch0_unchanged", hi1, 64);

    // Coast then brake mid-period on channel 2.
    idle(5);
    cycle(1'b1, 2, 0);
    wait_wrap();
    idle(100);
    chk("coast_ch2", int'({in_1_o[2], in_2_o[2]}), 0);
    stop_r[2] = 1'b1;
    cycle(1'b0, 0, 0);
    chk("brake_on_ch2", int'({in_1_o[2], in_2_o[2]}), 3);
    idle(10);
    stop_r[2] = 1'b0;
    cycle(1'b0, 0, 0);
    chk("brake_release_ch2", int'({in_1_o[2], in_2_o[2]}), 0);

    // Capture landing on the wrap edge is deferred by one period.
    while (m_cnt != PERIOD - 1) cycle(1'b0, 0, 0);
    cycle(1'b1, 0, 750);
    measure(0, hi1, hi2, first2);
    chk("wrap_capture_deferred", hi1, 64);
    wait_wrap();
    measure(0, hi1, hi2, first2);
    chk("wrap_capture_applied", hi1, 135);

    // Reversal on channel 3: FWD 750 then REV 750.
    idle(5);
    cycle(1'b1, 3, 750);
    wait_wrap();
    idle(5);
    cycle(1'b1, 3, -750);
    wait_wrap();
    measure(3, hi1, hi2, first2);
    chk("reverse_in1_high", hi1, 0);
    chk("reverse_in2_high", hi2, DT_EN ? 108 : 135);
    chk("reverse_in2_first", first2, DT_EN ? DEADTIME : 0);

    // Mid-period reset with captures attempted while held.
    idle(100);
    rstn = 1'b0;
    #1;
    model_reset();
    chk("reset_gates", int'({in_1_o, in_2_o}), 0);
    chk("reset_flags", int'({period_start_o, chn_err_o}), 0);
    for (int i = 0; i < NUM_CHN; i++) begin
      u_valid_i = 1'b1;
      u_chn_i   = 3'(i);
      u_data_i  = 16'd999;
      @(posedge clk);
      @(negedge clk);
      compare();
    end
    u_valid_i = 1'b0;
    rstn = 1'b1;
    cycle(1'b0, 0, 0);
    chk("reset_period_realign", int'(period_start_o), 1);
    cycle(1'b0, 0, 0);
    chk("reset_period_pulse_end", int'(period_start_o), 0);

    // Randomized captures and brake toggles against the model.
    for (int i = 0; i < PERIOD * 30; i++) begin
      v  = 1'b0;
      ch = 0;
      d  = 0;
      r  = $urandom;
      if ((m_cnt >= 3) && (m_cnt <= PERIOD - 4) && (r[4:0] == 5'd0)) begin
        v  = 1'b1;
        ch = int'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0: d = 0;
          1: d = int'($urandom_range(0, 4000)) - 2000;
          2: begin
            r = $urandom;
            d = int'($signed(r[15:0]));
          end
          default: d = ($urandom_range(0, 1) == 1) ? RPM_MAX : -RPM_MAX;
        endcase
      end
      if (r[12:5] == 8'd0) begin
        ch = ch;
        stop_r[$urandom_range(0, NUM_CHN - 1)] ^= 1'b1;
      end
      cycle(v, ch, d);
    end
    stop_r = '0;
    idle(PERIOD + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
